bdc_frame_controller: RTL

Frame-level sequencer for the barrel-distortion correction core. It sits on the input AXI4-Stream ahead of the core and snoops the core's output stream. It admits exactly one frame at a time and drops stray beats before start-of-frame. It applies double-buffered coefficient/centre configuration only at frame boundaries, and recovers the core with a watchdog reset if the pipeline stalls.

---
 rtl/bdc_pkg.sv | 21 ++
 rtl/bdc_cfg_regs.sv | 57 +++++
 rtl/bdc_frame_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bdc_pkg.sv
// Shared types and constants for the barrel-distortion correction core.
// Reset coefficients are reused by the core itself.
package bdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_RUN,
        S_DRAIN,
        S_RECOVER
    } state_e;

    localparam logic [1:0] CFG_K1 = 2'd0;
    localparam logic [1:0] CFG_K2 = 2'd1;
    localparam logic [1:0] CFG_CX = 2'd2;
    localparam logic [1:0] CFG_CY = 2'd3;

    localparam logic [15:0] K1_RST = 16'h0200;
    localparam logic [15:0] K2_RST = 16'h0040;

endpackage

// File: rtl/bdc_cfg_regs.sv
// Shadow/active coefficient and centre registers.
// Active set only changes on load_i; a same-cycle write lands in shadow only.
module bdc_cfg_regs
    import bdc_pkg::*;
#(
    parameter logic [15:0] CX_RST = 16'd960,
    parameter logic [15:0] CY_RST = 16'd540
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [15:0] wdata_i,
    input  logic        load_i,
    output logic [15:0] k1_o,
    output logic [15:0] k2_o,
    output logic [15:0] cx_o,
    output logic [15:0] cy_o
);

    logic [15:0] sh_k1_q, sh_k2_q, sh_cx_q, sh_cy_q;
    logic [15:0] k1_q, k2_q, cx_q, cy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_k1_q <= K1_RST;
            sh_k2_q <= K2_RST;
            sh_cx_q <= CX_RST;
            sh_cy_q <= CY_RST;
            k1_q    <= K1_RST;
            k2_q    <= K2_RST;
            cx_q    <= CX_RST;
            cy_q    <= CY_RST;
        end else begin
            if (we_i) begin
                unique case (addr_i)
                    CFG_K1: sh_k1_q <= wdata_i;
                    CFG_K2: sh_k2_q <= wdata_i;
                    CFG_CX: sh_cx_q <= wdata_i;
                    CFG_CY: sh_cy_q <= wdata_i;
                endcase
            end
            if (load_i) begin
                k1_q <= sh_k1_q;
                k2_q <= sh_k2_q;
                cx_q <= sh_cx_q;
                cy_q <= sh_cy_q;
            end
        end
    end

    assign k1_o = k1_q;
    assign k2_o = k2_q;
    assign cx_o = cx_q;
    assign cy_o = cy_q;

endmodule

// File: rtl/bdc_frame_controller.sv
// Frame sequencer ahead of the BDC core: SOF gating, frame counting,
// frame-boundary config load and watchdog-driven core recovery.
module bdc_frame_controller
    import bdc_pkg::*;
#(
    parameter int WIDTH      = 1920,
    parameter int HEIGHT     = 1080,
    parameter int DATA_WIDTH = 24,
    parameter int TO_WIDTH   = 24,
    parameter int RST_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_addr,
    input  logic [15:0]           cfg_wdata,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] c_tdata,
    output logic                  c_tvalid,
    output logic                  c_tuser,
    output logic                  c_tlast,
    input  logic                  c_tready,
    input  logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic                  m_tlast,
    output logic [15:0]           k1,
    output logic [15:0]           k2,
    output logic [15:0]           cx,
    output logic [15:0]           cy,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_timeout,
    output logic                  err_short,
    input  logic                  err_clr,
    output logic [15:0]           drop_cnt
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int RW    = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [RW-1:0] RC_LAST = RW'(RST_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d, wd_inc;
    logic [RW-1:0]       rc_q, rc_d;
    logic [15:0]         drop_q, drop_d;
    logic                to_q, to_d, short_q, short_d;
    logic                done_q, done_d, crst_q, crst_d;
    logic                to_set, short_set, load;
    logic                run_hs, m_hs;

    assign run_hs = s_tvalid & c_tready;
    assign m_hs   = m_tvalid & m_tready;
    assign wd_inc = wd_q + 1'b1;

    bdc_cfg_regs #(
        .CX_RST(16'(WIDTH / 2)),
        .CY_RST(16'(HEIGHT / 2))
    ) u_cfg (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (cfg_we),
        .addr_i (cfg_addr),
        .wdata_i(cfg_wdata),
        .load_i (load),
        .k1_o   (k1),
        .k2_o   (k2),
        .cx_o   (cx),
        .cy_o   (cy)
    );

    always_comb begin
        s_tready  = 1'b0;
        c_tvalid  = 1'b0;
        c_tdata   = '0;
        c_tuser   = 1'b0;
        c_tlast   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = '0;
        rc_d      = '0;
        drop_d    = drop_q;
        load      = 1'b0;
        done_d    = 1'b0;
        to_set    = 1'b0;
        short_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                // SOF is held off here so it reaches the core after the load
                s_tready = ~(s_tvalid & s_tuser);
                if (s_tvalid && !s_tuser && drop_q != 16'hFFFF)
                    drop_d = drop_q + 16'd1;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (s_tvalid && s_tuser) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                c_tvalid = s_tvalid;
                c_tdata  = s_tdata;
                c_tuser  = s_tuser;
                c_tlast  = s_tlast;
                s_tready = c_tready;
                wd_d     = (run_hs | m_hs) ? '0 : wd_inc;
                if (run_hs) begin
                    if (s_tuser && cnt_q != '0) begin
                        short_set = 1'b1;
                        cnt_d     = CW'(1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == TOTAL_C) state_d = S_DRAIN;
                end else if (!m_hs && wd_inc == '1) begin
                    to_set  = 1'b1;
                    state_d = S_RECOVER;
                end
            end
            S_DRAIN: begin
                wd_d = m_hs ? '0 : wd_inc;
                if (m_hs && m_tlast) begin
                    done_d  = 1'b1;
                    state_d = enable ? S_WAIT_SOF : S_IDLE;
                end else if (!m_hs && wd_inc == '1) begin
                    to_set  = 1'b1;
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                rc_d = rc_q + 1'b1;
                if (rc_q == RC_LAST) state_d = enable ? S_WAIT_SOF : S_IDLE;
            end
        endcase
        if (state_d != state_q) wd_d = '0;
        to_d    = (to_q & ~err_clr) | to_set;
        short_d = (short_q & ~err_clr) | short_set;
        crst_d  = (state_d != S_RECOVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wd_q    <= '0;
            rc_q    <= '0;
            drop_q  <= '0;
            to_q    <= 1'b0;
            short_q <= 1'b0;
            done_q  <= 1'b0;
            crst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            rc_q    <= rc_d;
            drop_q  <= drop_d;
            to_q    <= to_d;
            short_q <= short_d;
            done_q  <= done_d;
            crst_q  <= crst_d;
        end
    end

    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign frame_done  = done_q;
    assign core_rst_n  = crst_q;
    assign err_timeout = to_q;
    assign err_short   = short_q;
    assign drop_cnt    = drop_q;

endmodule
